// File: rtl/board_line_clear.sv
// Row-completion engine: scans the board RAM bottom-up, removes full rows and refills row 0.
// Optional macro LINE_CLEAR_SCORE_EN adds a saturating 16-bit score output.
module board_line_clear #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [5:0]        ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [5:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic [2:0]        lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [15:0]       score
`endif
);
    localparam int Y_W = $clog2(BOARD_H);
    localparam int X_W = $clog2(BOARD_W);
    localparam logic [X_W-1:0] LAST_X = X_W'(BOARD_W - 1);
    localparam logic [Y_W-1:0] TOP_Y  = Y_W'(BOARD_H - 1);

    typedef enum logic [2:0] {
        IDLE, CHK_RD, CHK_EVAL, SH_RD, SH_WAIT, SH_WR, CLR_TOP, DONE
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [Y_W-1:0] r_row, r_dst, w_dst_m1;
    logic [X_W-1:0] r_x;
    logic           r_full, r_busy;
    logic [2:0]     r_count, r_lines;
    logic           w_q_set, w_row_full;

    // Row index times ten built from shifts, matching the board's row-major layout.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [Y_W-1:0] y,
                                                     input logic [X_W-1:0] x);
        logic [ADDR_W+3:0] y_ext;
        logic [ADDR_W+3:0] x_ext;
        y_ext = {{(ADDR_W+4-Y_W){1'b0}}, y};
        x_ext = {{(ADDR_W+4-X_W){1'b0}}, x};
        cell_addr = ADDR_W'((y_ext << 3) + (y_ext << 1) + x_ext);
    endfunction

    assign w_q_set    = (ram_q != 6'd0);
    assign w_row_full = r_full & w_q_set;
    assign w_dst_m1   = r_dst - Y_W'(1);

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_addr    = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = CHK_RD;
            end
            CHK_RD: begin
                ram_addr = cell_addr(r_row, r_x);
                if (r_x == LAST_X) w_state_nxt = CHK_EVAL;
            end
            CHK_EVAL: begin
                if (w_row_full)          w_state_nxt = (r_row == '0) ? CLR_TOP : SH_RD;
                else if (r_row == '0)    w_state_nxt = DONE;
                else                     w_state_nxt = CHK_RD;
            end
            SH_RD: begin
                ram_addr    = cell_addr(w_dst_m1, r_x);
                w_state_nxt = SH_WAIT;
            end
            SH_WAIT: begin
                ram_addr    = cell_addr(w_dst_m1, r_x);
                w_state_nxt = SH_WR;
            end
            SH_WR: begin
                ram_addr = cell_addr(r_dst, r_x);
                ram_data = ram_q;
                ram_wren = 1'b1;
                if (r_x == LAST_X && r_dst == Y_W'(1)) w_state_nxt = CLR_TOP;
                else                                   w_state_nxt = SH_RD;
            end
            CLR_TOP: begin
                ram_addr = cell_addr('0, r_x);
                ram_wren = 1'b1;
                if (r_x == LAST_X) w_state_nxt = CHK_RD;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Scan position and row accumulator; always reloaded when a scan starts.
    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: begin
                if (start) begin
                    r_row   <= TOP_Y;
                    r_x     <= '0;
                    r_count <= 3'd0;
                end
            end
            CHK_RD: begin
                r_full <= (r_x == '0) ? 1'b1 : (r_full & w_q_set);
                r_x    <= (r_x == LAST_X) ? '0 : r_x + X_W'(1);
            end
            CHK_EVAL: begin
                if (w_row_full) begin
                    r_count <= (r_count == 3'd7) ? r_count : r_count + 3'd1;
                    r_dst   <= r_row;
                    r_x     <= '0;
                end else if (r_row != '0) begin
                    r_row <= r_row - Y_W'(1);
                end
            end
            SH_WR: begin
                if (r_x == LAST_X) begin
                    r_x   <= '0;
                    r_dst <= w_dst_m1;
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
            CLR_TOP: begin
                r_x <= (r_x == LAST_X) ? '0 : r_x + X_W'(1);
            end
            default: ;
        endcase
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] r_score;

    function automatic logic [15:0] score_inc(input logic [2:0] n);
        case (n)
            3'd0:    score_inc = 16'd0;
            3'd1:    score_inc = 16'd40;
            3'd2:    score_inc = 16'd100;
            3'd3:    score_inc = 16'd300;
            default: score_inc = 16'd1200;
        endcase
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add16 = s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign score = r_score;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_busy  <= 1'b0;
            r_lines <= 3'd0;
`ifdef LINE_CLEAR_SCORE_EN
            r_score <= 16'd0;
`endif
        end else begin
            if (r_state == IDLE && start) r_busy <= 1'b1;
            if (r_state == DONE) begin
                r_busy  <= 1'b0;
                r_lines <= r_count;
`ifdef LINE_CLEAR_SCORE_EN
                r_score <= sat_add16(r_score, score_inc(r_count));
`endif
            end
        end
    end

    assign busy          = r_busy;
    assign lines_cleared = r_lines;

endmodule

// File: tb/tb_board_line_clear.sv
// Scoreboard bench for board_line_clear: a board-level model predicts the final RAM,
// cleared-row count, scan latency and write count for every scan.
module tb_board_line_clear;
    localparam int W = 10;
    localparam int H = 20;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       resetn, start;
    logic [5:0] ram_q, ram_data;
    logic [7:0] ram_addr;
    logic       ram_wren, busy, done;
    logic [2:0] lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score;
`endif

    always #5 clk = ~clk;

    board_line_clear dut (
        .clk(clk), .resetn(resetn), .start(start), .ram_q(ram_q),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .busy(busy), .done(done), .lines_cleared(lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
        , .score(score)
`endif
    );

    logic [5:0] mem [0:N-1];
    logic [5:0] img [0:N-1];
    logic       ld;

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < N; i++) mem[i] <= img[i];
        end else if (ram_wren && ram_addr < 8'(N)) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= (ram_addr < 8'(N)) ? mem[ram_addr] : 6'h00;
    end

    typedef struct packed {
        logic [2:0]      lines;
        logic [31:0]     lat;
        logic [31:0]     writes;
`ifdef LINE_CLEAR_SCORE_EN
        logic [15:0]     score;
`endif
        logic [H*60-1:0] board;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_done   = 0;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] exp_score = 16'd0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    // Board-level reference: full rows vanish, survivors keep order and sink to the bottom.
    task automatic model(output exp_t e);
        logic [59:0] rows [H];
        bit          full [H];
        int          k, r, dsty;
        e = '0;
        for (int y = 0; y < H; y++) begin
            full[y] = 1'b1;
            for (int x = 0; x < W; x++) begin
                rows[y][x*6 +: 6] = img[y*W + x];
                if (img[y*W + x] == 6'd0) full[y] = 1'b0;
            end
        end
        k = 0;
        for (int y = H - 1; y >= 0; y--) begin
            if (full[y]) begin
                r = y + k;
                e.lat    += 32'(30 * r + 10);
                e.writes += 32'(10 * r + 10);
                k++;
            end
        end
        e.lat += 32'(11 * (H + k) + 1);
        dsty = H - 1;
        for (int y = H - 1; y >= 0; y--) begin
            if (!full[y]) begin
                e.board[dsty*60 +: 60] = rows[y];
                dsty--;
            end
        end
        e.lines = (k > 7) ? 3'd7 : 3'(k);
`ifdef LINE_CLEAR_SCORE_EN
        begin
            int add, s;
            add = (k == 0) ? 0 : (k == 1) ? 40 : (k == 2) ? 100 : (k == 3) ? 300 : 1200;
            s = int'(exp_score) + add;
            e.score = (s > 65535) ? 16'hFFFF : 16'(s);
        end
`endif
    endtask

    initial begin : monitor
        int   bcyc, wcyc;
        logic pend;
        exp_t e;
        bcyc = 0; wcyc = 0; pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                chk("lines_cleared", 64'(lines_cleared), 64'(e.lines));
`ifdef LINE_CLEAR_SCORE_EN
                chk("score", 64'(score), 64'(e.score));
`endif
                for (int y = 0; y < H; y++) begin
                    logic [59:0] row;
                    for (int x = 0; x < W; x++) row[x*6 +: 6] = mem[y*W + x];
                    chk($sformatf("board_row%0d", y), 64'(row), 64'(e.board[y*60 +: 60]));
                end
                n_done++;
            end
            if (!busy) begin
                if (ram_wren) chk("wren_while_idle", 64'(ram_wren), 64'(0));
                bcyc = 0;
                wcyc = 0;
            end else begin
                bcyc++;
                if (ram_wren) wcyc++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("scan_latency", 64'(bcyc), 64'(e.lat));
                    chk("write_count", 64'(wcyc), 64'(e.writes));
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic clear_img();
        for (int i = 0; i < N; i++) img[i] = 6'd0;
    endtask

    task automatic fill_row(input int y, input logic [5:0] c);
        for (int x = 0; x < W; x++) img[y*W + x] = (c != 6'd0) ? c : 6'($urandom_range(1, 63));
    endtask

    task automatic load_img();
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic kick();
        exp_t e;
        model(e);
        exp_q.push_back(e);
`ifdef LINE_CLEAR_SCORE_EN
        exp_score = e.score;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t0, lim;
        t0 = n_done;
        lim = 0;
        while (n_done == t0 && lim < 30000) begin
            @(negedge clk);
            lim++;
        end
        if (n_done == t0) begin
            chk("scan_timeout_cycles", 64'(lim), 64'(0));
            exp_q.delete();
        end
    endtask

    task automatic scan();
        load_img();
        kick();
        wait_done();
    endtask

    task automatic random_board();
        int r;
        clear_img();
        for (int y = 0; y < H; y++) begin
            r = $urandom_range(0, 9);
            if (y >= 8 && r < 3) begin
                fill_row(y, 6'd0);
            end else if ((y >= 8 && r < 7) || (y < 8 && r == 0)) begin
                for (int x = 0; x < W; x++)
                    img[y*W + x] = ($urandom_range(0, 9) < 7) ? 6'($urandom_range(1, 63)) : 6'd0;
                img[y*W + $urandom_range(0, W - 1)] = 6'd0;
            end
        end
    endtask

    initial begin : stim
        int base, lim;
        resetn = 1'b0; start = 1'b0; ld = 1'b0;
        clear_img();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_wren", 64'(ram_wren), 64'(0));
        chk("rst_lines", 64'(lines_cleared), 64'(0));
        chk("rst_addr", 64'(ram_addr), 64'(0));
        chk("rst_data", 64'(ram_data), 64'(0));
        resetn = 1'b1;
        @(negedge clk);

        clear_img();
        scan();

        clear_img();
        fill_row(19, 6'h0C);
        img[18*W + 3] = 6'h30;
        scan();

        clear_img();
        for (int y = 16; y < 20; y++) fill_row(y, 6'd0);
        img[15*W + 0] = 6'h03;
        scan();

        clear_img();
        fill_row(19, 6'd0);
        fill_row(17, 6'd0);
        fill_row(18, 6'd0);
        img[18*W + 9] = 6'd0;
        for (int x = 0; x < W; x += 2) img[16*W + x] = 6'(x + 1);
        scan();

        random_board();
        fill_row(19, 6'd0);
        load_img();
        base = n_done;
        kick();
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        chk("done_pulses", 64'(n_done - base), 64'(1));

        random_board();
        fill_row(19, 6'd0);
        load_img();
        kick();
        lim = 0;
        while (!ram_wren && lim < 2000) begin
            @(negedge clk);
            lim++;
        end
        chk("reach_sh_wr", 64'(ram_wren), 64'(1));
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_wren", 64'(ram_wren), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_lines", 64'(lines_cleared), 64'(0));
        resetn = 1'b1;
        void'(exp_q.pop_back());
`ifdef LINE_CLEAR_SCORE_EN
        exp_score = 16'd0;
`endif
        for (int i = 0; i < N; i++) img[i] = mem[i];
        scan();

        clear_img();
        for (int y = 10; y < 20; y++) fill_row(y, 6'd0);
        img[9*W + 4] = 6'h15;
        scan();

        clear_img();
        fill_row(0, 6'd0);
        img[5*W + 7] = 6'h2A;
        scan();

        for (int t = 0; t < 8; t++) begin
            random_board();
            scan();
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin : watchdog
        #990000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
